// File: rtl/gray_bin_arbiter_pkg.sv
// Shared types and constants for the two-requester Gray-to-binary arbiter.
package gray_bin_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic REQ_0 = 1'b0;
    localparam logic REQ_1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gray_bin_arbiter_if.sv
// Request/grant/result bundle between the requesters (master) and the arbiter (slave).
interface gray_bin_arbiter_if
    import gray_bin_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             req0;
    logic [WIDTH-1:0] g0_in;
    logic             req1;
    logic [WIDTH-1:0] g1_in;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] b_out;

    modport master (
        output req0, g0_in, req1, g1_in,
        input  gnt0, gnt1, busy, done, done_id, b_out
    );

    modport slave (
        input  req0, g0_in, req1, g1_in,
        output gnt0, gnt1, busy, done, done_id, b_out
    );
endinterface

// File: rtl/gray_bin_arbiter_engine.sv
// Bit-serial Gray-to-binary converter: one result bit per step, MSB first.
module gray_serial_engine #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_result,
    output logic             o_last_bit
);
    localparam int             IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]  IDX_TOP = IW'(WIDTH - 1);

    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] r_result;
    logic [IW-1:0]    r_idx;
    logic             w_bit;

    // The previously resolved bit sits in r_result[0]; it is zero before the MSB step.
    assign w_bit      = r_result[0] ^ r_gray[WIDTH-1];
    assign o_result   = r_result;
    assign o_last_bit = (r_idx == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gray   <= '0;
            r_result <= '0;
            r_idx    <= IDX_TOP;
        end else if (i_load) begin
            r_gray   <= i_gray;
            r_result <= '0;
            r_idx    <= IDX_TOP;
        end else if (i_step) begin
            r_gray   <= r_gray << 1;
            r_result <= (r_result << 1) | WIDTH'(w_bit);
            if (r_idx != '0) begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_bin_arbiter.sv
// Round-robin arbiter between two requesters sharing one bit-serial Gray-to-binary engine.
//   state | meaning
//   IDLE  | sample requests, grant and load the winner's Gray word
//   CONV  | resolve one bit per cycle, MSB first
//   DONE  | pulse done, present result, update last_served
module gray_bin_arbiter
    import gray_bin_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                clk,
    input logic                rst,
    gray_bin_arbiter_if.slave  bus
);
    state_t           r_state;
    state_t           w_next;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done_id;
    logic             r_last_served;
    logic [WIDTH-1:0] r_b_hold;
    logic [WIDTH-1:0] w_gray;
    logic [WIDTH-1:0] w_result;
    logic             w_any_req;
    logic             w_pick1;
    logic             w_load;
    logic             w_step;
    logic             w_last_bit;
    logic             w_busy;
    logic             w_done;

    assign w_any_req = bus.req0 | bus.req1;
    assign w_pick1   = bus.req1 & (~bus.req0 | (r_last_served == REQ_0));
    assign w_gray    = w_pick1 ? bus.g1_in : bus.g0_in;

    gray_serial_engine #(.WIDTH(WIDTH)) u_engine (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_gray     (w_gray),
        .o_result   (w_result),
        .o_last_bit (w_last_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next = CONV;
            CONV:    if (w_last_bit) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE:    w_load = w_any_req;
            CONV:    begin w_step = 1'b1; w_busy = 1'b1; end
            DONE:    begin w_done = 1'b1; w_busy = 1'b1; end
            default: ;
        endcase
    end

    // last_served resets to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_done_id     <= REQ_0;
            r_last_served <= REQ_1;
            r_b_hold      <= '0;
        end else if (w_load) begin
            r_gnt0    <= ~w_pick1;
            r_gnt1    <= w_pick1;
            r_done_id <= w_pick1 ? REQ_1 : REQ_0;
        end else if (w_done) begin
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_last_served <= r_done_id;
            r_b_hold      <= w_result;
        end
    end

    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.done_id = r_done_id;
    assign bus.b_out   = w_done ? w_result : r_b_hold;

endmodule
